// File: rtl/pong_pkg.sv
// Shared types, constants and helpers for the pong paddle front-end.
package pong_pkg;

  localparam int POS_W_DEF = 9;

  // Gray codes of the forward (up) sequence, written {A,B}.
  localparam logic [1:0] GRAY_UP_0 = 2'b00;
  localparam logic [1:0] GRAY_UP_1 = 2'b01;
  localparam logic [1:0] GRAY_UP_2 = 2'b11;
  localparam logic [1:0] GRAY_UP_3 = 2'b10;

  typedef enum logic [1:0] {
    EV_NONE = 2'd0,
    EV_UP   = 2'd1,
    EV_DOWN = 2'd2,
    EV_ERR  = 2'd3
  } quad_ev_e;

  // Adds a -1/0/+1 step to a signed byte, clamping at +127 / -128.
  function automatic logic signed [7:0] sat_add8(input logic signed [7:0] a,
                                                 input logic signed [1:0] b);
    logic signed [8:0] s;
    s = 9'(a) + 9'(b);
    if (s > 9'sd127) return 8'sd127;
    if (s < -9'sd128) return -8'sd128;
    return s[7:0];
  endfunction

endpackage

// File: rtl/quad_paddle_decoder_if.sv
// Encoder inputs, game-stage controls and decoded paddle outputs as one bundle.
interface quad_paddle_decoder_if
  import pong_pkg::*;
#(
  parameter int POS_W = POS_W_DEF
) ();

  logic             quadA;
  logic             quadB;
  logic             frame_tick;
  logic             clear;
  logic [POS_W-1:0] position;
  logic             step_up;
  logic             step_down;
  logic             quad_err;
  logic [7:0]       err_count;
  logic [7:0]       delta;
  logic             delta_valid;

  // Pulses are single-cycle strobes; there is no backpressure on any output.
  modport master (
    output quadA, quadB, frame_tick, clear,
    input  position, step_up, step_down, quad_err, err_count, delta, delta_valid
  );

  modport slave (
    input  quadA, quadB, frame_tick, clear,
    output position, step_up, step_down, quad_err, err_count, delta, delta_valid
  );

endinterface

// File: rtl/quad_chan_filter.sv
// One encoder channel: multi-flop synchroniser followed by a persistence filter.
module quad_chan_filter #(
  parameter int SYNC_STAGES = 2,
  parameter int FILT_LEN    = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw_i,
  output logic filt_o
);

  localparam int CNT_W = $clog2(FILT_LEN + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILT_LEN - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   synced;
  logic                   filt_q, filt_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;

  assign synced = sync_q[SYNC_STAGES-1];
  assign filt_o = filt_q;

  // A new level is accepted only after FILT_LEN consecutive differing samples.
  always_comb begin
    filt_d = filt_q;
    cnt_d  = cnt_q;
    if (synced == filt_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_LAST) begin
      filt_d = synced;
      cnt_d  = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      filt_q <= 1'b0;
      cnt_q  <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], raw_i};
      filt_q <= filt_d;
      cnt_q  <= cnt_d;
    end
  end

endmodule

// File: rtl/quad_paddle_decoder.sv
// Quadrature paddle decoder: x4 decode, saturating position, error count, per-frame delta.
module quad_paddle_decoder
  import pong_pkg::*;
#(
  parameter int POS_W       = POS_W_DEF,
  parameter int POS_MAX     = 511,
  parameter int POS_INIT    = 0,
  parameter int SYNC_STAGES = 2,
  parameter int FILT_LEN    = 4,
  parameter int DIR_INVERT  = 0
) (
  input logic                  clk,
  input logic                  rst_n,
  quad_paddle_decoder_if.slave bus
);

  localparam logic [POS_W-1:0] POS_MAX_V  = POS_W'(POS_MAX);
  localparam logic [POS_W-1:0] POS_INIT_V = POS_W'(POS_INIT);
  localparam logic             INVERT     = (DIR_INVERT != 0);

  logic             filt_a, filt_b;
  logic [1:0]       prev_q;
  logic             a_chg, b_chg;
  quad_ev_e         ev;
  logic signed [1:0] step_val;

  logic [POS_W-1:0] pos_q, pos_d;
  logic [7:0]       err_cnt_q, err_cnt_d;
  logic signed [7:0] acc_q, acc_d;
  logic signed [7:0] delta_q, delta_d;
  logic             dv_q, dv_d;
  logic             up_q, down_q, err_q;

  quad_chan_filter #(.SYNC_STAGES(SYNC_STAGES), .FILT_LEN(FILT_LEN)) u_filt_a (
    .clk(clk), .rst_n(rst_n), .raw_i(bus.quadA), .filt_o(filt_a)
  );

  quad_chan_filter #(.SYNC_STAGES(SYNC_STAGES), .FILT_LEN(FILT_LEN)) u_filt_b (
    .clk(clk), .rst_n(rst_n), .raw_i(bus.quadB), .filt_o(filt_b)
  );

  assign a_chg = prev_q[1] ^ filt_a;
  assign b_chg = prev_q[0] ^ filt_b;

  // Single-channel change is forward when old A differs from new B.
  always_comb begin
    ev = EV_NONE;
    if (a_chg && b_chg) begin
      ev = EV_ERR;
    end else if (a_chg || b_chg) begin
      ev = ((prev_q[1] != filt_b) ^ INVERT) ? EV_UP : EV_DOWN;
    end
  end

  assign step_val = (ev == EV_UP)   ? 2'sb01 :
                    (ev == EV_DOWN) ? 2'sb11 : 2'sb00;

  always_comb begin
    pos_d     = pos_q;
    err_cnt_d = err_cnt_q;
    acc_d     = acc_q;
    delta_d   = delta_q;
    dv_d      = 1'b0;

    if (bus.clear) begin
      pos_d = POS_INIT_V;
    end else if (ev == EV_UP && pos_q != POS_MAX_V) begin
      pos_d = pos_q + 1'b1;
    end else if (ev == EV_DOWN && pos_q != '0) begin
      pos_d = pos_q - 1'b1;
    end

    if (ev == EV_ERR && err_cnt_q != 8'hFF) begin
      err_cnt_d = err_cnt_q + 8'd1;
    end

    // A step landing on the tick closes into this frame's delta.
    if (bus.frame_tick) begin
      delta_d = bus.clear ? 8'sd0 : sat_add8(acc_q, step_val);
      acc_d   = '0;
      dv_d    = 1'b1;
    end else if (bus.clear) begin
      acc_d = '0;
    end else begin
      acc_d = sat_add8(acc_q, step_val);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_q    <= 2'b00;
      pos_q     <= POS_INIT_V;
      err_cnt_q <= '0;
      acc_q     <= '0;
      delta_q   <= '0;
      dv_q      <= 1'b0;
      up_q      <= 1'b0;
      down_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      prev_q    <= {filt_a, filt_b};
      pos_q     <= pos_d;
      err_cnt_q <= err_cnt_d;
      acc_q     <= acc_d;
      delta_q   <= delta_d;
      dv_q      <= dv_d;
      up_q      <= (ev == EV_UP);
      down_q    <= (ev == EV_DOWN);
      err_q     <= (ev == EV_ERR);
    end
  end

  assign bus.position    = pos_q;
  assign bus.step_up     = up_q;
  assign bus.step_down   = down_q;
  assign bus.quad_err    = err_q;
  assign bus.err_count   = err_cnt_q;
  assign bus.delta       = delta_q;
  assign bus.delta_valid = dv_q;

endmodule

// File: doc/quad_paddle_decoder.md
Name: quad_paddle_decoder

Overview:
- Front-end for the pong paddle. It decodes a mechanical quadrature encoder (quadA/quadB) into a saturating paddle position that the game stage consumes directly.
- It synchronises and glitch-filters both channels, then does x4 decode and flags illegal transitions.
- It also reports the signed motion per video frame, sampled on a frame tick from the game stage.

Parameters:
POS_W, 9, width of position output
POS_MAX, 511, upper saturation limit of position (<= 2^POS_W-1)
POS_INIT, 0, position value after reset and after clear
SYNC_STAGES, 2, synchroniser flops per channel (>=2)
FILT_LEN, 4, consecutive cycles a synced level must differ before it is accepted (>=1)
DIR_INVERT, 0, 1 swaps up/down sense

Ports:
clk  input  1  system clock; the one clock of the block
rst_n  input  1  asynchronous active-low reset
quadA  input  1  encoder channel A, asynchronous
quadB  input  1  encoder channel B, asynchronous
frame_tick  input  1  one-cycle pulse per video frame
clear  input  1  synchronous; forces position to POS_INIT and zeroes the delta accumulator
position  output  POS_W  paddle position, registered
step_up  output  1  one-cycle pulse on a decoded +1 step
step_down  output  1  one-cycle pulse on a decoded -1 step
quad_err  output  1  one-cycle pulse on an illegal transition (both channels changed)
err_count  output  8  saturating illegal-transition count
delta  output  8  signed motion over the last completed frame, two's complement
delta_valid  output  1  one-cycle pulse when delta is updated

Behaviour:
- Interface:
  - One clock (clk).
  - Reset rst_n is asynchronous and active-low.
  - All state is cleared on assertion; outputs are registered.
- Reset values:
  - position=POS_INIT.
  - step_up, step_down, quad_err, delta_valid = 0.
  - err_count=0, delta=0.
  - Synchroniser, filter and previous-state registers = 0.
- Synchroniser: SYNC_STAGES flops per channel.
- Filter, per channel:
  - Counter cnt of width clog2(FILT_LEN+1).
  - If synced == filt: cnt<=0.
  - Else if cnt==FILT_LEN-1: filt<=synced, cnt<=0.
  - Else: cnt++.
  - Any pulse shorter than FILT_LEN cycles after synchronisation is rejected.
- Decode: prev<=filt each cycle. Compare {A,B} of prev against filt:
  - No change: no event.
  - Exactly one channel changed: up if prev.A != filt.B, otherwise down. The up sequence is 00->01->11->10->00. DIR_INVERT swaps up and down.
  - Both changed: quad_err pulse; no position or delta change; err_count++ saturating at 255.
- Position:
  - Priority: clear > step.
  - Up at POS_MAX holds; down at 0 holds.
  - step_up/step_down pulse even when position is held at a limit.
- Latency: a stable level first captured at edge N yields a position change and step pulse at edge N+SYNC_STAGES+FILT_LEN.
- Delta accumulator acc:
  - Signed 8-bit, saturating at +127/-128.
  - Counts every decoded step, independent of position saturation.
- On frame_tick:
  - delta<=sat(acc + step_this_cycle); acc<=0; delta_valid<=1 next cycle only.
  - A step coinciding with frame_tick is counted in the closing frame.
  - clear and frame_tick together: delta<=0 with delta_valid=1; acc<=0.
- Back-to-back ticks are legal: each reports the steps since the previous tick.
- Reset mid-stream:
  - All counts are lost.
  - The first transition after reset is decoded from the reset state 00. An encoder resting at 11 therefore produces a quad_err only if both filtered channels flip in the same cycle; otherwise it produces a normal step.

Decomposition:
- Shared package pong_pkg:
  - POS_W default.
  - Up-sequence constants (gray codes 2'b00, 2'b01, 2'b11, 2'b10).
  - Function sat_add8 used for the delta accumulator.
- Sub-module quad_chan_filter (synchroniser + glitch filter, one channel), instantiated twice.
- Decode, position, error and delta logic stay in the top.

Test Plan:
- Reset, then 8 clean forward cycles (00->01->11->10 repeated, each level held 10 clks) -> position 32, 32 step_up pulses, quad_err never asserted, err_count 0.
- Quadrature reverse from position 2 for 5 steps -> position 0, step_down pulses 5, position held at 0; frame_tick afterwards -> delta = -5 (8'hFB), delta_valid high exactly 1 cycle.
- Glitch of 3 clks on quadA with FILT_LEN=4 -> no step, position unchanged. Same glitch of 4 clks -> exactly one step, with the step pulse at edge N+6 after first capture.
- Drive quadA and quadB to toggle simultaneously from 00 to 11 -> one quad_err pulse, err_count 1, position unchanged. Repeat 300 times -> err_count saturates at 255.
- 200 forward steps with no frame_tick, then tick -> delta 127. Step on the same cycle as frame_tick -> step is included in that delta, and the next frame starts at 0.
- clear asserted together with a step_up at position 100 -> position POS_INIT (0), acc 0. Assert rst_n low mid-stream with async timing -> all outputs at reset values before the next clk edge.
